flit_packetizer: RTL and testbench
==================================

Name: flit_packetizer

Overview:
- Upstream neighbour of the per-packet flit FIFO in the Flitzip datapath.
- Accepts one whole packet (FLITS x FLIT_WIDTH bits) over a valid/ready handshake.
- Serialises the packet into FLITS flits, one per clock, driving the FIFO's wr_en/data_in pair.
- Marks head and tail flits. Supports zero-bubble back-to-back packets.

Parameters:
- FLIT_WIDTH, 128, bits per flit; matches the FIFO input width.
- FLITS, 5, flits per packet; must be >= 1.
- EN_BITS, 3, width of the flit index; must satisfy 2**EN_BITS >= FLITS.

Ports:
- clk_in  input  1  single clock; all state changes on its rising edge.
- rst_in  input  1  reset, asynchronous and active-high.
- pkt_valid  input  1  the source presents a packet.
- pkt_ready  output  1  the block can accept a packet this cycle (combinational).
- pkt_data  input  FLITS*FLIT_WIDTH  packet payload; flit k = pkt_data[k*FLIT_WIDTH +: FLIT_WIDTH], so flit 0 is the LSBs.
- wr_en  output  1  registered write strobe to the FIFO.
- data_out  output  FLIT_WIDTH  registered flit to the FIFO data_in.
- flit_head  output  1  the current data_out is flit 0.
- flit_tail  output  1  the current data_out is flit FLITS-1.
- flit_idx  output  EN_BITS  index of the current flit.
- busy  output  1  state == SEND.

Behaviour:
- FSM states: IDLE and SEND. Reset puts the FSM in IDLE.
- Reset values: wr_en=0, data_out=0, flit_head=0, flit_tail=0, flit_idx=0, busy=0. The internal shift register is cleared.
- pkt_ready = (state==IDLE) || (state==SEND && flit_idx==FLITS-1). It is combinational and has no dependence on pkt_valid.
- An accept occurs at any rising edge where pkt_valid && pkt_ready. On an accept:
  - data_out<=flit 0, wr_en<=1, flit_head<=1, flit_idx<=0.
  - flit_tail<=(FLITS==1).
  - Flits 1..FLITS-1 are latched into the shift register. State goes to SEND.
- Latency: flit 0 is visible on data_out one cycle after the accepting edge. Flit k is visible k cycles after flit 0.
- SEND with flit_idx<FLITS-1:
  - Each edge outputs the next flit: flit_idx+1, wr_en=1, flit_head=0.
  - flit_tail=1 exactly when the new index is FLITS-1.
  - pkt_valid is ignored in this phase.
- SEND with flit_idx==FLITS-1, with an accept at the edge: a new packet starts with no bubble. wr_en stays 1 and flit_head=1.
- SEND with flit_idx==FLITS-1, no accept at the edge:
  - wr_en<=0, flit_head<=0, flit_tail<=0; state goes to IDLE.
  - data_out and flit_idx hold their last values.
- IDLE with no accept: wr_en stays 0 and all outputs hold.
- pkt_data is sampled only on the accepting edge. Later changes on pkt_data have no effect.
- FLITS==1: every packet is a single flit with head and tail both 1. pkt_ready is permanently 1.
- Reset asserted mid-packet:
  - The packet is dropped and outputs return to reset values immediately (asynchronous).
  - No further wr_en pulses occur until a new accept after reset deasserts.
- Exactly FLITS wr_en pulses are produced per accepted packet, in contiguous cycles. The block never stalls: the FIFO has no backpressure.

Optional Feature:
- Macro: FLIT_PARITY_EN.
- When defined:
  - Adds output port flit_parity (1 bit, registered).
  - flit_parity = XOR reduction of the data_out value loaded on the same edge, giving even parity over data_out plus flit_parity.
  - Reset value is 0. The value holds when wr_en=0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package flitzip_pkg holds:
  - FLIT_WIDTH, FLITS and EN_BITS defaults.
  - The state typedef (IDLE, SEND).
  - A localparam PKT_WIDTH = FLITS*FLIT_WIDTH.
- The FIFO and this block both use the package defaults.
- No sub-module. The shift register and FSM stay in one module of about 150 lines.

Test Plan:
- Single packet:
  - Stimulus: FLITS=5, flit k = {16{8'h10+k}}, pkt_valid pulsed for one cycle in IDLE.
  - Response: wr_en high for exactly 5 cycles; data_out sequence is 0x10..10, 0x11..11, up to 0x14..14.
  - Response: head only on the first flit, tail only on the fifth; flit_idx runs 0..4; then IDLE with wr_en=0.
- Back-to-back:
  - Stimulus: pkt_valid held high with packet A (flits 0xA0+k), then packet B (flits 0xB0+k).
  - Response: 10 contiguous wr_en cycles with no bubble; head at cycles 1 and 6; tail at cycles 5 and 10.
  - Response: pkt_ready high only while flit_idx==4.
- Ignore while busy:
  - Stimulus: pkt_valid pulsed during flit_idx==1 with a different payload.
  - Response: no accept; data_out continues with the original packet; pkt_ready=0.
- Reset mid-packet:
  - Stimulus: assert rst_in asynchronously at flit_idx==2, release, then send packet 0xC0+k.
  - Response: outputs are zero immediately; the remaining flits 3..4 of the old packet never appear.
  - Response: the new packet emits 5 clean flits starting with head.
- Payload isolation:
  - Stimulus: change pkt_data every cycle after the accept.
  - Response: the emitted flits equal the payload captured at the accepting edge.
- FLIT_PARITY_EN:
  - Stimulus: flit 128'h1 then 128'h3.
  - Response: flit_parity is 1 then 0.

Source files
------------

// File: rtl/flitzip_pkg.sv
// Shared Flitzip datapath definitions: flit geometry and the packetizer state encoding.
package flitzip_pkg;

  localparam int FLIT_WIDTH = 128;
  localparam int FLITS      = 5;
  localparam int EN_BITS    = 3;
  localparam int PKT_WIDTH  = FLITS * FLIT_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/flit_packetizer_if.sv
// Packet-side valid/ready handshake carrying one whole packet per transfer.
interface flit_packetizer_if;
  import flitzip_pkg::*;

  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [PKT_WIDTH-1:0] pkt_data;

  modport master (output pkt_valid, output pkt_data, input pkt_ready);
  modport slave  (input pkt_valid, input pkt_data, output pkt_ready);

endinterface

// File: rtl/flit_packetizer.sv
// Packet-to-flit serialiser feeding the per-packet flit FIFO.
// Optional macro FLIT_PARITY_EN adds a registered even-parity bit per flit.
//
// state | meaning
// IDLE  | no packet in flight, wr_en low, outputs hold
// SEND  | emitting flits of the current packet, one per clock
module flit_packetizer
  import flitzip_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  flit_packetizer_if.slave      pkt_if,
  output logic                  wr_en,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic                  flit_head,
  output logic                  flit_tail,
  output logic [EN_BITS-1:0]    flit_idx,
  output logic                  busy
`ifdef FLIT_PARITY_EN
  , output logic                flit_parity
`endif
);

  localparam logic [EN_BITS-1:0] LAST_IDX = EN_BITS'(FLITS - 1);
  // Flit 0 goes straight to data_out, so only FLITS-1 flits need holding.
  localparam int SHIFT_W = (FLITS > 1) ? (FLITS - 1) * FLIT_WIDTH : FLIT_WIDTH;

  state_t                state_q, state_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [FLIT_WIDTH-1:0] data_q, data_d;
  logic [EN_BITS-1:0]    idx_q, idx_d, idx_inc;
  logic                  wr_q, wr_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic                  last_flit;
  logic                  ready;
  logic                  accept;
  logic                  load;

  assign last_flit = (idx_q == LAST_IDX);
  assign idx_inc   = idx_q + EN_BITS'(1);
  assign ready     = (state_q == IDLE) || ((state_q == SEND) && last_flit);
  assign accept    = pkt_if.pkt_valid && ready;

  assign pkt_if.pkt_ready = ready;
  assign wr_en     = wr_q;
  assign data_out  = data_q;
  assign flit_head = head_q;
  assign flit_tail = tail_q;
  assign flit_idx  = idx_q;
  assign busy      = (state_q == SEND);

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: an accept always (re)enters SEND; the last flit without an accept drops to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (last_flit && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: load flit 0 on accept, otherwise step through the shift register.
  always_comb begin
    shift_d = shift_q;
    data_d  = data_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    head_d  = head_q;
    tail_d  = tail_q;
    load    = 1'b0;
    if (accept) begin
      load    = 1'b1;
      data_d  = pkt_if.pkt_data[FLIT_WIDTH-1:0];
      shift_d = SHIFT_W'(pkt_if.pkt_data >> FLIT_WIDTH);
      idx_d   = '0;
      wr_d    = 1'b1;
      head_d  = 1'b1;
      tail_d  = (FLITS == 1);
    end else if (state_q == SEND && !last_flit) begin
      load    = 1'b1;
      data_d  = shift_q[FLIT_WIDTH-1:0];
      shift_d = shift_q >> FLIT_WIDTH;
      idx_d   = idx_inc;
      wr_d    = 1'b1;
      head_d  = 1'b0;
      tail_d  = (idx_inc == LAST_IDX);
    end else if (state_q == SEND) begin
      // data_out and flit_idx deliberately keep the last flit.
      wr_d    = 1'b0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end
  end

  // Datapath registers; async reset drops any packet in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef FLIT_PARITY_EN
  logic parity_q;

  assign flit_parity = parity_q;

  // Parity tracks each newly loaded flit and holds otherwise.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)    parity_q <= 1'b0;
    else if (load) parity_q <= ^data_d;
  end
`else
  logic unused_load;
  assign unused_load = load;
`endif

endmodule

// File: tb/tb_flit_packetizer.sv
// Directed self-checking bench for flit_packetizer (default FLITS=5, FLIT_WIDTH=128).
module tb_flit_packetizer;
  import flitzip_pkg::*;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  wr_en;
  logic [FLIT_WIDTH-1:0] data_out;
  logic                  flit_head;
  logic                  flit_tail;
  logic [EN_BITS-1:0]    flit_idx;
  logic                  busy;
`ifdef FLIT_PARITY_EN
  logic                  flit_parity;
`endif

  int n_checks = 0;
  int n_errors = 0;

  flit_packetizer_if pkt_if ();

  flit_packetizer dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .pkt_if    (pkt_if),
    .wr_en     (wr_en),
    .data_out  (data_out),
    .flit_head (flit_head),
    .flit_tail (flit_tail),
    .flit_idx  (flit_idx),
    .busy      (busy)
`ifdef FLIT_PARITY_EN
    , .flit_parity (flit_parity)
`endif
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [FLIT_WIDTH-1:0] flit_of(input logic [7:0] base, input int k);
    logic [7:0] b;
    b = base + 8'(k);
    return {16{b}};
  endfunction

  function automatic logic [PKT_WIDTH-1:0] mk_pkt(input logic [7:0] base);
    logic [PKT_WIDTH-1:0] p;
    p = '0;
    for (int k = 0; k < FLITS; k++) p[k*FLIT_WIDTH +: FLIT_WIDTH] = flit_of(base, k);
    return p;
  endfunction

  task automatic chkw(input string tag, input logic [FLIT_WIDTH-1:0] obs, input logic [FLIT_WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_flit(input string tag, input logic [FLIT_WIDTH-1:0] exp_data, input int k);
    chk1({tag, " wr_en"}, wr_en, 1'b1);
    chkw({tag, " data_out"}, data_out, exp_data);
    chk1({tag, " head"}, flit_head, k == 0);
    chk1({tag, " tail"}, flit_tail, k == FLITS - 1);
    chkw({tag, " idx"}, FLIT_WIDTH'(flit_idx), FLIT_WIDTH'(k));
    chk1({tag, " busy"}, busy, 1'b1);
    chk1({tag, " ready"}, pkt_if.pkt_ready, k == FLITS - 1);
  endtask

  task automatic chk_idle(input string tag, input logic [FLIT_WIDTH-1:0] exp_data, input int exp_idx);
    chk1({tag, " wr_en"}, wr_en, 1'b0);
    chkw({tag, " data_out"}, data_out, exp_data);
    chk1({tag, " head"}, flit_head, 1'b0);
    chk1({tag, " tail"}, flit_tail, 1'b0);
    chkw({tag, " idx"}, FLIT_WIDTH'(flit_idx), FLIT_WIDTH'(exp_idx));
    chk1({tag, " busy"}, busy, 1'b0);
    chk1({tag, " ready"}, pkt_if.pkt_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PKT_WIDTH-1:0] pa, pb;

    // Reset state.
    rst_in = 1'b1;
    pkt_if.pkt_valid = 1'b0;
    pkt_if.pkt_data  = '0;
    #3;
    chk_idle("reset", '0, 0);
`ifdef FLIT_PARITY_EN
    chk1("reset parity", flit_parity, 1'b0);
`endif
    tick();
    rst_in = 1'b0;
    tick();
    chk_idle("idle after reset", '0, 0);

    // Single packet, one-cycle valid pulse.
    pkt_if.pkt_valid = 1'b1;
    pkt_if.pkt_data  = mk_pkt(8'h10);
    tick();
    pkt_if.pkt_valid = 1'b0;
    for (int k = 0; k < FLITS; k++) begin
      chk_flit("single", flit_of(8'h10, k), k);
      tick();
    end
    chk_idle("single end", flit_of(8'h10, 4), 4);
    tick();
    chk_idle("single hold", flit_of(8'h10, 4), 4);

    // Back-to-back packets with valid held high.
    pa = mk_pkt(8'hA0);
    pb = mk_pkt(8'hB0);
    pkt_if.pkt_valid = 1'b1;
    pkt_if.pkt_data  = pa;
    tick();
    pkt_if.pkt_data  = pb;
    for (int c = 0; c < 2 * FLITS; c++) begin
      chk_flit("b2b", (c < FLITS) ? flit_of(8'hA0, c % FLITS) : flit_of(8'hB0, c % FLITS), c % FLITS);
      if (c == 2 * FLITS - 1) pkt_if.pkt_valid = 1'b0;
      tick();
    end
    chk_idle("b2b end", flit_of(8'hB0, 4), 4);

    // Valid while busy is ignored.
    pkt_if.pkt_valid = 1'b1;
    pkt_if.pkt_data  = mk_pkt(8'h30);
    tick();
    pkt_if.pkt_valid = 1'b0;
    chk_flit("busy", flit_of(8'h30, 0), 0);
    tick();
    chk_flit("busy", flit_of(8'h30, 1), 1);
    pkt_if.pkt_valid = 1'b1;
    pkt_if.pkt_data  = mk_pkt(8'hE0);
    tick();
    pkt_if.pkt_valid = 1'b0;
    for (int k = 2; k < FLITS; k++) begin
      chk_flit("busy", flit_of(8'h30, k), k);
      tick();
    end
    chk_idle("busy end", flit_of(8'h30, 4), 4);

    // Reset mid-packet at flit_idx==2.
    pkt_if.pkt_valid = 1'b1;
    pkt_if.pkt_data  = mk_pkt(8'h20);
    tick();
    pkt_if.pkt_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_flit("pre-reset", flit_of(8'h20, k), k);
      if (k < 2) tick();
    end
    #2;
    rst_in = 1'b1;
    #1;
    chk_idle("async reset", '0, 0);
`ifdef FLIT_PARITY_EN
    chk1("async reset parity", flit_parity, 1'b0);
`endif
    tick();
    chk1("in reset wr_en", wr_en, 1'b0);
    rst_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_idle("post reset", '0, 0);
    end

    // New packet after reset with pkt_data changing every cycle after the accept.
    pkt_if.pkt_valid = 1'b1;
    pkt_if.pkt_data  = mk_pkt(8'hC0);
    tick();
    pkt_if.pkt_valid = 1'b0;
    for (int k = 0; k < FLITS; k++) begin
      pkt_if.pkt_data = mk_pkt(8'(8'h60 + 8'(k * 16)));
      chk_flit("isolation", flit_of(8'hC0, k), k);
      tick();
    end
    chk_idle("isolation end", flit_of(8'hC0, 4), 4);

`ifdef FLIT_PARITY_EN
    begin
      logic [PKT_WIDTH-1:0] pp;
      logic exp_par [FLITS];
      pp = '0;
      pp[0*FLIT_WIDTH +: FLIT_WIDTH] = 128'h1;
      pp[1*FLIT_WIDTH +: FLIT_WIDTH] = 128'h3;
      pp[2*FLIT_WIDTH +: FLIT_WIDTH] = 128'h7;
      exp_par[0] = 1'b1;
      exp_par[1] = 1'b0;
      exp_par[2] = 1'b1;
      exp_par[3] = 1'b0;
      exp_par[4] = 1'b0;
      pkt_if.pkt_valid = 1'b1;
      pkt_if.pkt_data  = pp;
      tick();
      pkt_if.pkt_valid = 1'b0;
      for (int k = 0; k < FLITS; k++) begin
        chkw("parity data", data_out, pp[k*FLIT_WIDTH +: FLIT_WIDTH]);
        chk1("parity bit", flit_parity, exp_par[k]);
        tick();
      end
      chk1("parity hold", flit_parity, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
